mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, single-outstanding data-memory access FSM
// with alignment/timeout faults, lane steering for stores and load extension, MEM/WB register.
module mem_stage #(
  parameter int unsigned DMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] ALU_result_ex_out,
  input  logic [31:0] rs2,
  input  logic [31:0] instr_ex_in,
  input  logic        valid_ex,
  input  logic        memread_ex,
  input  logic        memwrite_ex,
  input  logic        regwrite_ex,
  input  logic        flush,
  output logic [31:0] ALU_result_ex_mem_out,
  output logic [4:0]  rd_ex_mem_out,
  output logic        regwrite_ex_mem_out,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_fault
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] TMO_LAST = 8'(DMEM_TIMEOUT - 1);

  // Legal funct3/alignment combinations; anything else becomes a fault.
  function automatic logic access_ok(input logic [2:0] f3, input logic is_store,
                                     input logic [1:0] a);
    case (f3)
      3'b000:  access_ok = 1'b1;
      3'b001:  access_ok = ~a[0];
      3'b010:  access_ok = (a == 2'b00);
      3'b100:  access_ok = ~is_store;
      3'b101:  access_ok = ~is_store & ~a[0];
      default: access_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << a;
      2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'd0, sh[7:0]};
      3'b101:  load_ext = {16'd0, sh[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  logic        in_valid, in_mem, in_fault, in_issue;
  logic        busy, timeout_hit;
  state_t      state_q;
  logic [7:0]  tcnt_q;

  logic        exm_valid_d, exm_memwrite_d, exm_regwrite_d, exm_fault_d;
  logic [4:0]  exm_rd_d;
  logic [2:0]  exm_funct3_d;
  logic [31:0] exm_alu_d, exm_wdata_d;
  logic        exm_valid_q, exm_memwrite_q, exm_regwrite_q, exm_fault_q;
  logic [4:0]  exm_rd_q;
  logic [2:0]  exm_funct3_q;
  logic [31:0] exm_alu_q, exm_wdata_q;

  logic        wb_valid_d, wb_regwrite_d, wb_fault_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;
  logic        wb_valid_q, wb_regwrite_q, wb_fault_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        unused_instr;
  assign unused_instr = ^{instr_ex_in[31:15], instr_ex_in[6:0]};

  assign in_valid = valid_ex & ~flush;
  assign in_mem   = memread_ex | memwrite_ex;
  assign in_fault = in_valid & in_mem &
                    ~access_ok(instr_ex_in[14:12], memwrite_ex, ALU_result_ex_out[1:0]);
  assign in_issue = in_valid & in_mem & ~in_fault;

  assign busy        = (state_q == BUSY);
  assign timeout_hit = busy & (tcnt_q == TMO_LAST);
  assign mem_stall   = busy & ~dmem_ready & ~timeout_hit;

  // EX -> EX/MEM boundary
  always_comb begin
    exm_valid_d    = in_valid;
    exm_rd_d       = in_valid ? instr_ex_in[11:7] : 5'd0;
    exm_memwrite_d = in_valid & memwrite_ex;
    exm_regwrite_d = in_valid & regwrite_ex;
    exm_fault_d    = in_fault;
    exm_funct3_d   = instr_ex_in[14:12];
    exm_alu_d      = ALU_result_ex_out;
    exm_wdata_d    = rs2;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exm_valid_q    <= 1'b0;
      exm_rd_q       <= '0;
      exm_memwrite_q <= 1'b0;
      exm_regwrite_q <= 1'b0;
      exm_fault_q    <= 1'b0;
      exm_funct3_q   <= '0;
      exm_alu_q      <= '0;
      exm_wdata_q    <= '0;
    end else if (!mem_stall) begin
      exm_valid_q    <= exm_valid_d;
      exm_rd_q       <= exm_rd_d;
      exm_memwrite_q <= exm_memwrite_d;
      exm_regwrite_q <= exm_regwrite_d;
      exm_fault_q    <= exm_fault_d;
      exm_funct3_q   <= exm_funct3_d;
      exm_alu_q      <= exm_alu_d;
      exm_wdata_q    <= exm_wdata_d;
    end
  end

  // A completing access may hand over directly to the op captured on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
    end else if (mem_stall) begin
      tcnt_q  <= tcnt_q + 8'd1;
    end else begin
      state_q <= in_issue ? BUSY : IDLE;
      tcnt_q  <= '0;
    end
  end

  assign dmem_req   = busy;
  assign dmem_we    = busy & exm_memwrite_q;
  assign dmem_addr  = {exm_alu_q[31:2], 2'b00};
  assign dmem_wdata = store_lanes(exm_funct3_q, exm_wdata_q);
  assign dmem_be    = busy ? lane_be(exm_funct3_q, exm_alu_q[1:0]) : 4'b0000;

  // EX/MEM -> MEM/WB boundary
  always_comb begin
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_fault_d    = 1'b0;
    wb_rd_d       = exm_rd_q;
    wb_data_d     = exm_alu_q;
    if (mem_stall) begin
      wb_valid_d = 1'b0;
    end else if (busy) begin
      wb_valid_d = 1'b1;
      if (!dmem_ready) begin
        wb_fault_d = 1'b1;
      end else if (!exm_memwrite_q) begin
        wb_regwrite_d = exm_regwrite_q;
        wb_data_d     = load_ext(exm_funct3_q, exm_alu_q[1:0], dmem_rdata);
      end
    end else begin
      wb_valid_d    = exm_valid_q;
      wb_fault_d    = exm_fault_q;
      wb_regwrite_d = exm_regwrite_q & ~exm_fault_q & ~exm_memwrite_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_fault_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_fault_q    <= wb_fault_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign ALU_result_ex_mem_out = exm_alu_q;
  assign rd_ex_mem_out         = exm_rd_q;
  assign regwrite_ex_mem_out   = exm_regwrite_q;
  assign wb_valid              = wb_valid_q;
  assign wb_regwrite           = wb_regwrite_q;
  assign wb_rd                 = wb_rd_q;
  assign wb_data               = wb_data_q;
  assign mem_fault             = wb_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-op behaviour plus
// hand-written sequences for wait states, timeout and reset during an access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] ALU_result_ex_out = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] instr_ex_in = '0;
  logic        valid_ex = 1'b0, memread_ex = 1'b0, memwrite_ex = 1'b0, regwrite_ex = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ALU_result_ex_mem_out;
  logic [4:0]  rd_ex_mem_out;
  logic        regwrite_ex_mem_out, mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_regwrite, mem_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;

  mem_stage #(.DMEM_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .ALU_result_ex_out(ALU_result_ex_out), .rs2(rs2), .instr_ex_in(instr_ex_in),
    .valid_ex(valid_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
    .regwrite_ex(regwrite_ex), .flush(flush),
    .ALU_result_ex_mem_out(ALU_result_ex_mem_out), .rd_ex_mem_out(rd_ex_mem_out),
    .regwrite_ex_mem_out(regwrite_ex_mem_out), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        mr, mw, rw;
    logic [31:0] rdata;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_rw;
    logic        e_fault;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic [31:0] st, input logic [2:0] f3,
                        input logic [4:0] rd, input logic mr, input logic mw, input logic rw,
                        input logic v, input logic fl);
    ALU_result_ex_out = alu;
    rs2               = st;
    instr_ex_in       = {17'd0, f3, rd, 7'h03};
    memread_ex        = mr;
    memwrite_ex       = mw;
    regwrite_ex       = rw;
    valid_ex          = v;
    flush             = fl;
  endtask

  task automatic bubble();
    set_ex(32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_stall;
    bit  done;
    //             alu           st            f3    rd  mr mw rw rdata         req be       wdata         rw fl cd data
    vecs[0]  = '{32'h12345678, 32'h0,        3'd0, 5'd5, 0, 0, 1, 32'h0,        0, 4'b0000, 32'h0,        1, 0, 1, 32'h12345678};
    vecs[1]  = '{32'h00000103, 32'h0,        3'd0, 5'd6, 1, 0, 1, 32'h80FF0000, 1, 4'b0000, 32'h0,        1, 0, 1, 32'hFFFFFF80};
    vecs[2]  = '{32'h00000103, 32'h0,        3'd4, 5'd6, 1, 0, 1, 32'h80FF0000, 1, 4'b0000, 32'h0,        1, 0, 1, 32'h00000080};
    vecs[3]  = '{32'h00000102, 32'h0,        3'd1, 5'd7, 1, 0, 1, 32'h80011234, 1, 4'b0000, 32'h0,        1, 0, 1, 32'hFFFF8001};
    vecs[4]  = '{32'h00000100, 32'h0,        3'd5, 5'd8, 1, 0, 1, 32'h1234F00D, 1, 4'b0000, 32'h0,        1, 0, 1, 32'h0000F00D};
    vecs[5]  = '{32'h00000104, 32'h0,        3'd2, 5'd9, 1, 0, 1, 32'hCAFEBABE, 1, 4'b0000, 32'h0,        1, 0, 1, 32'hCAFEBABE};
    vecs[6]  = '{32'h00000301, 32'h000000A5, 3'd0, 5'd0, 0, 1, 1, 32'h0,        1, 4'b0010, 32'hA5A5A5A5, 0, 0, 0, 32'h0};
    vecs[7]  = '{32'h00000202, 32'h1234ABCD, 3'd1, 5'd0, 0, 1, 0, 32'h0,        1, 4'b1100, 32'hABCDABCD, 0, 0, 0, 32'h0};
    vecs[8]  = '{32'h00000208, 32'h11223344, 3'd2, 5'd0, 0, 1, 0, 32'h0,        1, 4'b1111, 32'h11223344, 0, 0, 0, 32'h0};
    vecs[9]  = '{32'h00000101, 32'h0,        3'd2, 5'd3, 1, 0, 1, 32'h0,        0, 4'b0000, 32'h0,        0, 1, 0, 32'h0};
    vecs[10] = '{32'h00000203, 32'h0000BEEF, 3'd1, 5'd0, 0, 1, 0, 32'h0,        0, 4'b0000, 32'h0,        0, 1, 0, 32'h0};
    vecs[11] = '{32'h00000100, 32'h0,        3'd3, 5'd4, 1, 0, 1, 32'h0,        0, 4'b0000, 32'h0,        0, 1, 0, 32'h0};
    vecs[12] = '{32'h00000101, 32'h0,        3'd5, 5'd4, 1, 0, 1, 32'h0,        0, 4'b0000, 32'h0,        0, 1, 0, 32'h0};

    // Reset state
    repeat (2) tick();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_exm_alu", ALU_result_ex_mem_out, 32'd0);
    chk("rst_exm_rd", 32'(rd_ex_mem_out), 32'd0);
    chk("rst_exm_rw", 32'(regwrite_ex_mem_out), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Zero-wait table
    for (int i = 0; i < 13; i++) begin
      set_ex(vecs[i].alu, vecs[i].st, vecs[i].f3, vecs[i].rd,
             vecs[i].mr, vecs[i].mw, vecs[i].rw, 1'b1, 1'b0);
      dmem_ready = 1'b1;
      dmem_rdata = vecs[i].rdata;
      tick();
      bubble();
      #1;
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_wb_idle", i), 32'(wb_valid | mem_fault), 32'd0);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].alu & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd0);
        chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].mw));
        if (vecs[i].mw) begin
          chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vecs[i].e_be));
          chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
        end
      end
      tick();
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_wb_rw", i), 32'(wb_regwrite), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d_fault", i), 32'(mem_fault), 32'(vecs[i].e_fault));
      chk($sformatf("v%0d_req_done", i), 32'(dmem_req), 32'd0);
      if (vecs[i].e_rw) chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
      if (vecs[i].chk_data) chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_data);
    end
    tick();
    chk("fault_pulse_end", 32'(mem_fault), 32'd0);

    // LW with one wait state; a flushed op offered during the stall is ignored
    set_ex(32'h100, 32'h0, 3'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    n_stall = 0;
    tick();
    set_ex(32'h55, 32'h0, 3'd0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("w1_req", 32'(dmem_req), 32'd1);
    if (mem_stall) n_stall++;
    tick();
    chk("w1_exm_hold", ALU_result_ex_mem_out, 32'h100);
    chk("w1_addr_hold", dmem_addr, 32'h100);
    chk("w1_wb_bubble", 32'(wb_valid), 32'd0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    bubble();
    #1;
    if (mem_stall) n_stall++;
    tick();
    chk("w1_stall_cycles", 32'(n_stall), 32'd1);
    chk("w1_wb_valid", 32'(wb_valid), 32'd1);
    chk("w1_wb_data", wb_data, 32'hDEADBEEF);
    chk("w1_wb_rw", 32'(wb_regwrite), 32'd1);
    chk("w1_req_done", 32'(dmem_req), 32'd0);

    // Timeout abort
    set_ex(32'h400, 32'h0, 3'd2, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    tick();
    bubble();
    #1;
    n_stall = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (mem_stall) begin
        n_stall++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    chk("to_bound", 32'(done), 32'd1);
    chk("to_stall_cycles", 32'(n_stall), 32'd15);
    tick();
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_fault", 32'(mem_fault), 32'd1);
    chk("to_wb_rw", 32'(wb_regwrite), 32'd0);
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    tick();
    chk("to_fault_pulse", 32'(mem_fault), 32'd0);
    chk("to_wb_bubble", 32'(wb_valid), 32'd0);

    // Reset during an access, then an ADD passes through
    set_ex(32'h500, 32'h0, 3'd2, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    tick();
    bubble();
    #1;
    chk("rb_req_before", 32'(dmem_req), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("rb_req_drop", 32'(dmem_req), 32'd0);
    chk("rb_stall_drop", 32'(mem_stall), 32'd0);
    chk("rb_wb_valid", 32'(wb_valid), 32'd0);
    chk("rb_exm_alu", ALU_result_ex_mem_out, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    set_ex(32'hABC, 32'h0, 3'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    bubble();
    chk("rb_add_exm", ALU_result_ex_mem_out, 32'hABC);
    chk("rb_add_exm_rd", 32'(rd_ex_mem_out), 32'd7);
    chk("rb_add_exm_rw", 32'(regwrite_ex_mem_out), 32'd1);
    chk("rb_no_stale_wb", 32'(wb_valid), 32'd0);
    tick();
    chk("rb_add_wb_valid", 32'(wb_valid), 32'd1);
    chk("rb_add_wb_data", wb_data, 32'hABC);
    chk("rb_add_wb_rw", 32'(wb_regwrite), 32'd1);
    chk("rb_add_wb_rd", 32'(wb_rd), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
